// File: rtl/decode_stage_if.sv
// Fetch-to-execute bundle of the RV32I decode stage: fetch handshake, flush,
// and the decoded bundle presented to execute.
interface decode_stage_if #(
    parameter int CPU_WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [CPU_WIDTH-1:0] in_instr;
    logic [CPU_WIDTH-1:0] in_pc;
    logic                 flush;

    logic                 out_valid;
    logic                 out_ready;
    logic [CPU_WIDTH-1:0] out_pc;
    logic [CPU_WIDTH-1:0] out_instr;
    logic [4:0]           rs1_addr;
    logic [4:0]           rs2_addr;
    logic [4:0]           rd_addr;
    logic [CPU_WIDTH-1:0] imm;
    logic [3:0]           alu_sel;
    logic [2:0]           op_class;
    logic                 use_imm;
    logic                 src_a_pc;
    logic                 reg_we;
    logic                 mem_re;
    logic                 mem_we;
    logic                 illegal;

    // The decode stage itself.
    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_instr, rs1_addr, rs2_addr, rd_addr,
               imm, alu_sel, op_class, use_imm, src_a_pc, reg_we, mem_re, mem_we, illegal
    );

    // The surrounding fetch and execute logic.
    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, rs1_addr, rs2_addr, rd_addr,
               imm, alu_sel, op_class, use_imm, src_a_pc, reg_we, mem_re, mem_we, illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: one registered slot between fetch and execute,
// decoding immediates and execute control, with valid/ready stall and flush.
module decode_stage #(
    parameter int          CPU_WIDTH = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave dec
);

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_sel_e;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_JAL    = 3'd4,
        CLS_JALR   = 3'd5,
        CLS_UPPER  = 3'd6,
        CLS_NONE   = 3'd7
    } op_class_e;

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_BRANCH = 7'b1100011,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_FENCE  = 7'b0001111
    } opcode_e;

    typedef struct packed {
        logic [CPU_WIDTH-1:0] imm;
        alu_sel_e             alu_sel;
        op_class_e            op_class;
        logic                 use_imm;
        logic                 src_a_pc;
        logic                 reg_we;
        logic                 mem_re;
        logic                 mem_we;
        logic                 illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{
        imm: '0, alu_sel: ALU_ADD, op_class: CLS_NONE, use_imm: 1'b0,
        src_a_pc: 1'b0, reg_we: 1'b0, mem_re: 1'b0, mem_we: 1'b0, illegal: 1'b0
    };

    // funct3 -> ALU op for the register/immediate arithmetic groups (funct7 = 0).
    function automatic alu_sel_e f3_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [CPU_WIDTH-1:0] w;
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic [CPU_WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    ctrl_t                ctrl_d;

    assign w      = dec.in_instr;
    assign opcode = w[6:0];
    assign funct3 = w[14:12];
    assign funct7 = w[31:25];

    assign imm_i = {{20{w[31]}}, w[31:20]};
    assign imm_s = {{20{w[31]}}, w[31:25], w[11:7]};
    assign imm_b = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    assign imm_u = {w[31:12], 12'b0};
    assign imm_j = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};

    // NOTE: every field gets its default before the case, so no path through
    // this block leaves a signal unassigned and no latch is inferred.
    always_comb begin
        ctrl_d = CTRL_RESET;
        case (opcode)
            OPC_OP: begin
                ctrl_d.op_class = CLS_ALU;
                ctrl_d.reg_we   = 1'b1;
                if (funct7 == 7'h00)                         ctrl_d.alu_sel = f3_alu(funct3);
                else if (funct7 == 7'h20 && funct3 == 3'b000) ctrl_d.alu_sel = ALU_SUB;
                else if (funct7 == 7'h20 && funct3 == 3'b101) ctrl_d.alu_sel = ALU_SRA;
                else                                          ctrl_d.illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                ctrl_d.op_class = CLS_ALU;
                ctrl_d.imm      = imm_i;
                ctrl_d.use_imm  = 1'b1;
                ctrl_d.reg_we   = 1'b1;
                ctrl_d.alu_sel  = f3_alu(funct3);
                // Shift-immediates reuse the upper immediate bits as funct7.
                if (funct3 == 3'b001 && funct7 != 7'h00) ctrl_d.illegal = 1'b1;
                if (funct3 == 3'b101) begin
                    if (funct7 == 7'h20)      ctrl_d.alu_sel = ALU_SRA;
                    else if (funct7 != 7'h00) ctrl_d.illegal = 1'b1;
                end
            end
            OPC_LOAD: begin
                ctrl_d.op_class = CLS_LOAD;
                ctrl_d.imm      = imm_i;
                ctrl_d.use_imm  = 1'b1;
                ctrl_d.reg_we   = 1'b1;
                ctrl_d.mem_re   = 1'b1;
                ctrl_d.illegal  = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                ctrl_d.op_class = CLS_STORE;
                ctrl_d.imm      = imm_s;
                ctrl_d.use_imm  = 1'b1;
                ctrl_d.mem_we   = 1'b1;
                ctrl_d.illegal  = (funct3 > 3'b010);
            end
            OPC_BRANCH: begin
                ctrl_d.op_class = CLS_BRANCH;
                ctrl_d.imm      = imm_b;
                ctrl_d.alu_sel  = ALU_SUB;
                ctrl_d.illegal  = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_JAL: begin
                ctrl_d.op_class = CLS_JAL;
                ctrl_d.imm      = imm_j;
                ctrl_d.src_a_pc = 1'b1;
                ctrl_d.use_imm  = 1'b1;
                ctrl_d.reg_we   = 1'b1;
            end
            OPC_JALR: begin
                ctrl_d.op_class = CLS_JALR;
                ctrl_d.imm      = imm_i;
                ctrl_d.use_imm  = 1'b1;
                ctrl_d.reg_we   = 1'b1;
                ctrl_d.illegal  = (funct3 != 3'b000);
            end
            OPC_LUI: begin
                ctrl_d.op_class = CLS_UPPER;
                ctrl_d.imm      = imm_u;
                ctrl_d.alu_sel  = ALU_PASS_B;
                ctrl_d.use_imm  = 1'b1;
                ctrl_d.reg_we   = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl_d.op_class = CLS_UPPER;
                ctrl_d.imm      = imm_u;
                ctrl_d.src_a_pc = 1'b1;
                ctrl_d.use_imm  = 1'b1;
                ctrl_d.reg_we   = 1'b1;
            end
            OPC_FENCE: ctrl_d.op_class = CLS_NONE;
            default:   ctrl_d.illegal  = 1'b1;
        endcase

        // Execute traps on illegal bundles, so they must not touch any state.
        if (ctrl_d.illegal) begin
            ctrl_d.op_class = CLS_NONE;
            ctrl_d.reg_we   = 1'b0;
            ctrl_d.mem_re   = 1'b0;
            ctrl_d.mem_we   = 1'b0;
        end
        if (w[11:7] == 5'd0) ctrl_d.reg_we = 1'b0;
    end

    logic                 valid_q;
    logic [CPU_WIDTH-1:0] pc_q;
    logic [CPU_WIDTH-1:0] instr_q;
    ctrl_t                ctrl_q;
    logic                 take;

    assign dec.in_ready = !rst && (!valid_q || dec.out_ready);
    assign take         = dec.in_valid && dec.in_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || dec.flush) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
            ctrl_q  <= CTRL_RESET;
        end else if (take) begin
            valid_q <= 1'b1;
            pc_q    <= dec.in_pc;
            instr_q <= dec.in_instr;
            ctrl_q  <= ctrl_d;
        end else if (valid_q && dec.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Register indices are raw fields of the held word, so they stay registered.
    assign dec.out_valid = valid_q;
    assign dec.out_pc    = pc_q;
    assign dec.out_instr = instr_q;
    assign dec.rs1_addr  = instr_q[19:15];
    assign dec.rs2_addr  = instr_q[24:20];
    assign dec.rd_addr   = instr_q[11:7];
    assign dec.imm       = ctrl_q.imm;
    assign dec.alu_sel   = ctrl_q.alu_sel;
    assign dec.op_class  = ctrl_q.op_class;
    assign dec.use_imm   = ctrl_q.use_imm;
    assign dec.src_a_pc  = ctrl_q.src_a_pc;
    assign dec.reg_we    = ctrl_q.reg_we;
    assign dec.mem_re    = ctrl_q.mem_re;
    assign dec.mem_we    = ctrl_q.mem_we;
    assign dec.illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed decode table, stall/flush/reset sequences,
// and a randomized stream scored against a rule-level decode model.
module tb_decode_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_stage_if bus ();
    decode_stage dut (.clk(clk), .rst(rst), .dec(bus));

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [2:0]  cls;
        logic        use_imm, src_a_pc, reg_we, mem_re, mem_we, illegal;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        exp_t        e;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Decode rules written directly from the ISA tables.
    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        int f3 = int'(w[14:12]);
        int f7 = int'(w[31:25]);
        int alu_of_f3 [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        e = '0;
        e.cls = 3'd7;
        case (w[6:0])
            7'h33: begin
                e.cls = 0; e.reg_we = 1;
                if (f7 == 0) e.alu = 4'(alu_of_f3[f3]);
                else if (f7 == 32 && f3 == 0) e.alu = 1;
                else if (f7 == 32 && f3 == 5) e.alu = 7;
                else e.illegal = 1;
            end
            7'h13: begin
                e.cls = 0; e.reg_we = 1; e.use_imm = 1;
                e.imm = 32'($signed(w[31:20]));
                e.alu = 4'(alu_of_f3[f3]);
                if (f3 == 1 && f7 != 0) e.illegal = 1;
                if (f3 == 5 && f7 == 32) e.alu = 7;
                if (f3 == 5 && f7 != 0 && f7 != 32) e.illegal = 1;
            end
            7'h03: begin
                e.cls = 1; e.reg_we = 1; e.use_imm = 1; e.mem_re = 1;
                e.imm = 32'($signed(w[31:20]));
                e.illegal = (f3 == 3 || f3 >= 6);
            end
            7'h23: begin
                e.cls = 2; e.use_imm = 1; e.mem_we = 1;
                e.imm = 32'($signed({w[31:25], w[11:7]}));
                e.illegal = (f3 > 2);
            end
            7'h63: begin
                e.cls = 3; e.alu = 1;
                e.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8]})) * 2;
                e.illegal = (f3 == 2 || f3 == 3);
            end
            7'h6F: begin
                e.cls = 4; e.src_a_pc = 1; e.use_imm = 1; e.reg_we = 1;
                e.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21]})) * 2;
            end
            7'h67: begin
                e.cls = 5; e.use_imm = 1; e.reg_we = 1;
                e.imm = 32'($signed(w[31:20]));
                e.illegal = (f3 != 0);
            end
            7'h37: begin
                e.cls = 6; e.alu = 10; e.use_imm = 1; e.reg_we = 1;
                e.imm = w & 32'hFFFF_F000;
            end
            7'h17: begin
                e.cls = 6; e.src_a_pc = 1; e.use_imm = 1; e.reg_we = 1;
                e.imm = w & 32'hFFFF_F000;
            end
            7'h0F: e.cls = 7;
            default: e.illegal = 1;
        endcase
        if (e.illegal) begin
            e.cls = 7; e.reg_we = 0; e.mem_re = 0; e.mem_we = 0;
        end
        if (w[11:7] == 5'd0) e.reg_we = 0;
        return e;
    endfunction

    // Operand/immediate fields are only meaningful for legal encodings.
    task automatic check_bundle(input string tag, input logic [31:0] instr,
                                input logic [31:0] pc, input exp_t e);
        check({tag, " instr"},   bus.out_instr, instr);
        check({tag, " pc"},      bus.out_pc, pc);
        check({tag, " rs1"},     32'(bus.rs1_addr), 32'(instr[19:15]));
        check({tag, " rs2"},     32'(bus.rs2_addr), 32'(instr[24:20]));
        check({tag, " rd"},      32'(bus.rd_addr), 32'(instr[11:7]));
        check({tag, " illegal"}, 32'(bus.illegal), 32'(e.illegal));
        check({tag, " class"},   32'(bus.op_class), 32'(e.cls));
        check({tag, " reg_we"},  32'(bus.reg_we), 32'(e.reg_we));
        check({tag, " mem_re"},  32'(bus.mem_re), 32'(e.mem_re));
        check({tag, " mem_we"},  32'(bus.mem_we), 32'(e.mem_we));
        if (!e.illegal) begin
            check({tag, " imm"},      bus.imm, e.imm);
            check({tag, " alu_sel"},  32'(bus.alu_sel), 32'(e.alu));
            check({tag, " use_imm"},  32'(bus.use_imm), 32'(e.use_imm));
            check({tag, " src_a_pc"}, 32'(bus.src_a_pc), 32'(e.src_a_pc));
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, " out_instr"}, bus.out_instr, 32'h0000_0013);
        check({tag, " imm"},       bus.imm, 32'd0);
        check({tag, " alu_sel"},   32'(bus.alu_sel), 32'd0);
        check({tag, " class"},     32'(bus.op_class), 32'd7);
        check({tag, " flags"},     32'({bus.use_imm, bus.src_a_pc, bus.reg_we,
                                        bus.mem_re, bus.mem_we, bus.illegal}), 32'd0);
        check({tag, " regs"},      32'({bus.rs1_addr, bus.rs2_addr, bus.rd_addr}), 32'd0);
    endtask

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] imm,
                                input int alu, input int cls, input bit ui, input bit sp,
                                input bit we, input bit re, input bit mw, input bit ill);
        vec_t v;
        v.instr = instr;
        v.e = '{imm: imm, alu: 4'(alu), cls: 3'(cls), use_imm: ui, src_a_pc: sp,
                reg_we: we, mem_re: re, mem_we: mw, illegal: ill};
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [$];
        logic [31:0] stream [24];
        logic [31:0] q_instr [$];
        logic [31:0] q_pc [$];
        logic [6:0]  opcs [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                                   7'h67, 7'h37, 7'h17, 7'h0F, 7'h73};
        bit          mvalid;
        int          sent, got;

        //           instr          imm           alu cls ui sp we re mw ill
        vecs.push_back(mk(32'h0051_0093, 32'h0000_0005, 0,  0, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(32'hFE51_2E23, 32'hFFFF_FFFC, 0,  2, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(32'hFE00_0CE3, 32'hFFFF_FFF8, 1,  3, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h1234_51B7, 32'h1234_5000, 10, 6, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(32'hFFFF_FFFF, 32'h0000_0000, 0,  7, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(32'h4000_7013, 32'h0000_0400, 9,  0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h00C0_00EF, 32'h0000_000C, 0,  4, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(32'h0000_1297, 32'h0000_1000, 0,  6, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(32'hFFF3_A303, 32'hFFFF_FFFF, 0,  1, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(32'h4020_81B3, 32'h0000_0000, 1,  0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(32'h4032_5213, 32'h0000_0403, 7,  0, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(32'h0000_0073, 32'h0000_0000, 0,  7, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(32'h0000_B083, 32'h0000_0000, 0,  7, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(32'h0000_8067, 32'h0000_0000, 0,  5, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(32'h0FF0_000F, 32'h0000_0000, 0,  7, 0, 0, 0, 0, 0, 0));

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b0;
        repeat (2) step();
        check("reset in_ready", 32'(bus.in_ready), 32'd0);
        check("reset out_pc", bus.out_pc, 32'd0);
        check_idle("reset");

        // Back-to-back transfers with out_ready high: each replaces the last.
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = vecs[i].instr;
            bus.in_pc    = 32'h1000 + 32'(4 * i);
            step();
            check($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'd1);
            check_bundle($sformatf("vec%0d", i), vecs[i].instr, 32'h1000 + 32'(4 * i), vecs[i].e);
        end
        bus.in_valid = 1'b0;
        step();
        check("drain out_valid", 32'(bus.out_valid), 32'd0);

        // Stall three cycles with a pending instruction, then flush it away.
        bus.in_valid = 1'b1; bus.in_instr = 32'h4020_81B3; bus.in_pc = 32'h3000;
        step();
        bus.out_ready = 1'b0;
        bus.in_instr = 32'h0051_0093; bus.in_pc = 32'h3004;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall in_ready", 32'(bus.in_ready), 32'd0);
            step();
            check("stall out_valid", 32'(bus.out_valid), 32'd1);
            check_bundle("stall", 32'h4020_81B3, 32'h3000, model(32'h4020_81B3));
        end
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check_idle("flush");
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        step();
        check("flush dropped", 32'(bus.out_valid), 32'd0);

        // Random traffic scored against a one-entry queue model.
        foreach (stream[i]) begin
            stream[i] = $urandom;
            if ($urandom_range(7) != 0) begin
                stream[i][6:0] = opcs[$urandom_range(10)];
                if ($urandom_range(3) != 0) stream[i][31:25] = $urandom_range(1) ? 7'h20 : 7'h00;
            end
        end
        mvalid = 1'b0; sent = 0; got = 0;
        for (int cyc = 0; cyc < 600 && got < 24; cyc++) begin
            bit fire_in, fire_out;
            bus.in_valid  = (sent < 24) && ($urandom_range(3) != 0);
            bus.in_instr  = (sent < 24) ? stream[sent] : 32'h0;
            bus.in_pc     = 32'h2000 + 32'(4 * sent);
            bus.out_ready = ($urandom_range(2) != 0);
            #1;
            check("rnd in_ready", 32'(bus.in_ready), 32'(!mvalid || bus.out_ready));
            check("rnd out_valid", 32'(bus.out_valid), 32'(mvalid));
            if (mvalid) check_bundle("rnd", q_instr[0], q_pc[0], model(q_instr[0]));
            fire_out = mvalid && bus.out_ready;
            fire_in  = bus.in_valid && (!mvalid || bus.out_ready);
            if (fire_out) begin
                void'(q_instr.pop_front());
                void'(q_pc.pop_front());
                got++;
            end
            if (fire_in) begin
                q_instr.push_back(bus.in_instr);
                q_pc.push_back(bus.in_pc);
                sent++;
            end
            mvalid = fire_in ? 1'b1 : (fire_out ? 1'b0 : mvalid);
            step();
        end
        check("rnd delivered", 32'(got), 32'd24);

        // Reset mid-stream with a valid bundle held and fetch still presenting.
        bus.in_valid = 1'b1; bus.in_instr = 32'h0051_0093; bus.in_pc = 32'h4000;
        bus.out_ready = 1'b0;
        step();
        check("pre-rst out_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        step();
        check("rst in_ready", 32'(bus.in_ready), 32'd0);
        check("rst out_pc", bus.out_pc, 32'd0);
        check_idle("rst");
        rst = 1'b0;
        bus.in_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
